// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl_fsm
//  Description : Sequencing controller for a sliding-tile (2048-style) game.
//                Issues move and spawn requests to external engines, scans
//                the board one tile per cycle for win/lose conditions and
//                keeps the move counter and sticky end-of-game flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl_fsm #(
    parameter int GRID_N         = 4,
    parameter int TILE_W         = 4,
    parameter int CNT_W          = 16,
    parameter int ALLOW_CONTINUE = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              btn_up,
    input  logic                              btn_down,
    input  logic                              btn_left,
    input  logic                              btn_right,
    input  logic [TILE_W-1:0]                 win_goal,
    input  logic [GRID_N*GRID_N*TILE_W-1:0]   board,
    output logic                              mv_start,
    output logic [1:0]                        mv_dir,
    input  logic                              mv_done,
    input  logic                              mv_changed,
    output logic                              spawn_start,
    input  logic                              spawn_done,
    output logic                              move_en,
    output logic                              busy,
    output logic                              game_over,
    output logic                              game_completed,
    output logic [TILE_W-1:0]                 use_win_goal,
    output logic [CNT_W-1:0]                  move_count,
    output logic [2:0]                        state
);

    localparam int                NUM_TILES      = GRID_N * GRID_N;
    localparam int                IDX_W          = $clog2(NUM_TILES);
    localparam logic [IDX_W-1:0]  C_LAST_IDX     = IDX_W'(NUM_TILES - 1);
    localparam logic [TILE_W-1:0] C_DEFAULT_GOAL = TILE_W'(11);
    localparam logic [CNT_W-1:0]  C_CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_INIT  = 3'b000,
        S_IDLE  = 3'b001,
        S_MOVE  = 3'b010,
        S_SPAWN = 3'b011,
        S_SCAN  = 3'b100,
        S_WIN   = 3'b101,
        S_LOSE  = 3'b110
    } state_t;

    // Registered state
    state_t             r_state;
    logic               r_mv_start;
    logic [1:0]         r_mv_dir;
    logic               r_spawn_start;
    logic               r_game_over;
    logic               r_game_completed;
    logic               r_won_latched;
    logic [CNT_W-1:0]   r_move_count;
    logic [1:0]         r_spawn_cnt;
    logic               r_init_fill;      // spawns in progress belong to the initial board fill
    logic [IDX_W-1:0]   r_scan_idx;
    logic               r_found_goal;
    logic               r_found_empty;
    logic               r_found_merge;
    logic [TILE_W-1:0]  r_use_win_goal;

    // Next-state values
    state_t             w_state_nxt;
    logic               w_mv_start_nxt;
    logic [1:0]         w_mv_dir_nxt;
    logic               w_spawn_start_nxt;
    logic               w_game_over_nxt;
    logic               w_game_completed_nxt;
    logic               w_won_latched_nxt;
    logic [CNT_W-1:0]   w_move_count_nxt;
    logic [1:0]         w_spawn_cnt_nxt;
    logic               w_init_fill_nxt;
    logic [IDX_W-1:0]   w_scan_idx_nxt;
    logic               w_found_goal_nxt;
    logic               w_found_empty_nxt;
    logic               w_found_merge_nxt;
    logic [TILE_W-1:0]  w_use_win_goal_nxt;

    // Button decode: any press, and direction with up > down > left > right
    logic               w_btn_any;
    logic [1:0]         w_btn_dir;

    assign w_btn_any = btn_up | btn_down | btn_left | btn_right;
    assign w_btn_dir = btn_up   ? 2'b00 :
                       btn_down ? 2'b01 :
                       btn_left ? 2'b10 : 2'b11;

    // Per-tile condition maps. Neighbour comparisons are resolved statically
    // here so the scan only needs a single-bit mux per flag.
    logic [NUM_TILES-1:0] w_goal_map;
    logic [NUM_TILES-1:0] w_empty_map;
    logic [NUM_TILES-1:0] w_merge_map;

    generate
        for (genvar gr = 0; gr < GRID_N; gr++) begin : g_row
            for (genvar gc = 0; gc < GRID_N; gc++) begin : g_col
                localparam int IDX = gr * GRID_N + gc;
                logic [TILE_W-1:0] w_tile;
                logic              w_eq_right;
                logic              w_eq_down;

                assign w_tile = board[IDX*TILE_W +: TILE_W];

                if (gc < GRID_N - 1) begin : g_right
                    assign w_eq_right = (w_tile == board[(IDX+1)*TILE_W +: TILE_W]);
                end else begin : g_no_right
                    assign w_eq_right = 1'b0;
                end

                if (gr < GRID_N - 1) begin : g_down
                    assign w_eq_down = (w_tile == board[(IDX+GRID_N)*TILE_W +: TILE_W]);
                end else begin : g_no_down
                    assign w_eq_down = 1'b0;
                end

                assign w_goal_map[IDX]  = (w_tile >= r_use_win_goal);
                assign w_empty_map[IDX] = (w_tile == '0);
                assign w_merge_map[IDX] = (w_tile != '0) && (w_eq_right || w_eq_down);
            end
        end
    endgenerate

    // State register and all controller storage; reset returns to INIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_INIT;
            r_mv_start       <= 1'b0;
            r_mv_dir         <= 2'b00;
            r_spawn_start    <= 1'b0;
            r_game_over      <= 1'b0;
            r_game_completed <= 1'b0;
            r_won_latched    <= 1'b0;
            r_move_count     <= '0;
            r_spawn_cnt      <= 2'd0;
            r_init_fill      <= 1'b0;
            r_scan_idx       <= '0;
            r_found_goal     <= 1'b0;
            r_found_empty    <= 1'b0;
            r_found_merge    <= 1'b0;
            r_use_win_goal   <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_mv_start       <= w_mv_start_nxt;
            r_mv_dir         <= w_mv_dir_nxt;
            r_spawn_start    <= w_spawn_start_nxt;
            r_game_over      <= w_game_over_nxt;
            r_game_completed <= w_game_completed_nxt;
            r_won_latched    <= w_won_latched_nxt;
            r_move_count     <= w_move_count_nxt;
            r_spawn_cnt      <= w_spawn_cnt_nxt;
            r_init_fill      <= w_init_fill_nxt;
            r_scan_idx       <= w_scan_idx_nxt;
            r_found_goal     <= w_found_goal_nxt;
            r_found_empty    <= w_found_empty_nxt;
            r_found_merge    <= w_found_merge_nxt;
            r_use_win_goal   <= w_use_win_goal_nxt;
        end
    end

    // Next-state and next-value logic; request pulses default low, storage holds
    always_comb begin
        w_state_nxt          = r_state;
        w_mv_start_nxt       = 1'b0;
        w_mv_dir_nxt         = r_mv_dir;
        w_spawn_start_nxt    = 1'b0;
        w_game_over_nxt      = r_game_over;
        w_game_completed_nxt = r_game_completed;
        w_won_latched_nxt    = r_won_latched;
        w_move_count_nxt     = r_move_count;
        w_spawn_cnt_nxt      = r_spawn_cnt;
        w_init_fill_nxt      = r_init_fill;
        w_scan_idx_nxt       = r_scan_idx;
        w_found_goal_nxt     = r_found_goal;
        w_found_empty_nxt    = r_found_empty;
        w_found_merge_nxt    = r_found_merge;
        w_use_win_goal_nxt   = r_use_win_goal;

        case (r_state)
            S_INIT: begin
                w_use_win_goal_nxt = (win_goal == '0) ? C_DEFAULT_GOAL : win_goal;
                w_spawn_cnt_nxt    = 2'd0;
                w_init_fill_nxt    = 1'b1;
                w_spawn_start_nxt  = 1'b1;
                w_state_nxt        = S_SPAWN;
            end

            S_IDLE: begin
                if (w_btn_any) begin
                    w_mv_dir_nxt   = w_btn_dir;
                    w_mv_start_nxt = 1'b1;
                    w_state_nxt    = S_MOVE;
                end
            end

            S_MOVE: begin
                if (mv_done) begin
                    if (mv_changed) begin
                        if (r_move_count != C_CNT_MAX) begin
                            w_move_count_nxt = r_move_count + CNT_W'(1);
                        end
                        w_spawn_cnt_nxt   = 2'd0;
                        w_init_fill_nxt   = 1'b0;
                        w_spawn_start_nxt = 1'b1;
                        w_state_nxt       = S_SPAWN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_SPAWN: begin
                if (spawn_done) begin
                    w_spawn_cnt_nxt = r_spawn_cnt + 2'd1;
                    // The initial fill needs two tiles; a move needs one
                    if (r_init_fill && (r_spawn_cnt == 2'd0)) begin
                        w_spawn_start_nxt = 1'b1;
                    end else begin
                        w_init_fill_nxt   = 1'b0;
                        w_scan_idx_nxt    = '0;
                        w_found_goal_nxt  = 1'b0;
                        w_found_empty_nxt = 1'b0;
                        w_found_merge_nxt = 1'b0;
                        w_state_nxt       = S_SCAN;
                    end
                end
            end

            S_SCAN: begin
                w_found_goal_nxt  = r_found_goal  | w_goal_map[r_scan_idx];
                w_found_empty_nxt = r_found_empty | w_empty_map[r_scan_idx];
                w_found_merge_nxt = r_found_merge | w_merge_map[r_scan_idx];
                if (r_scan_idx == C_LAST_IDX) begin
                    // Verdict includes the final tile's contribution
                    if (w_found_goal_nxt && !r_won_latched) begin
                        w_game_completed_nxt = 1'b1;
                        w_state_nxt          = S_WIN;
                    end else if (!w_found_empty_nxt && !w_found_merge_nxt) begin
                        w_game_over_nxt = 1'b1;
                        w_state_nxt     = S_LOSE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_scan_idx_nxt = r_scan_idx + IDX_W'(1);
                end
            end

            S_WIN: begin
                // The continuing press is consumed here and never becomes a move
                if ((ALLOW_CONTINUE != 0) && w_btn_any) begin
                    w_won_latched_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end
            end

            S_LOSE: begin
                w_state_nxt = S_LOSE;
            end

            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    assign state          = r_state;
    assign mv_start       = r_mv_start;
    assign mv_dir         = r_mv_dir;
    assign spawn_start    = r_spawn_start;
    assign game_over      = r_game_over;
    assign game_completed = r_game_completed;
    assign move_count     = r_move_count;
    assign use_win_goal   = r_use_win_goal;
    assign move_en        = (r_state == S_IDLE);
    assign busy           = (r_state == S_INIT)  || (r_state == S_MOVE) ||
                            (r_state == S_SPAWN) || (r_state == S_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_ctrl_fsm
//  Description : Self-checking bench for game_ctrl_fsm (4x4 board, goal 11).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl_fsm;

    localparam int GRID_N = 4;
    localparam int TILE_W = 4;
    localparam int CNT_W  = 16;

    localparam logic [2:0] ST_INIT  = 3'b000;
    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_MOVE  = 3'b010;
    localparam logic [2:0] ST_SPAWN = 3'b011;
    localparam logic [2:0] ST_SCAN  = 3'b100;
    localparam logic [2:0] ST_WIN   = 3'b101;
    localparam logic [2:0] ST_LOSE  = 3'b110;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [TILE_W-1:0]               win_goal = 4'd11;
    logic [GRID_N*GRID_N*TILE_W-1:0] board = '0;
    logic                            mv_start;
    logic [1:0]                      mv_dir;
    logic                            mv_done = 1'b0, mv_changed = 1'b0;
    logic                            spawn_start;
    logic                            spawn_done = 1'b0;
    logic                            move_en, busy, game_over, game_completed;
    logic [TILE_W-1:0]               use_win_goal;
    logic [CNT_W-1:0]                move_count;
    logic [2:0]                      state;

    int errors = 0;
    int checks = 0;
    int spawn_pulses = 0;
    int mv_pulses = 0;

    always #5 clk = ~clk;

    game_ctrl_fsm #(
        .GRID_N(GRID_N), .TILE_W(TILE_W), .CNT_W(CNT_W), .ALLOW_CONTINUE(1)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .win_goal(win_goal), .board(board),
        .mv_start(mv_start), .mv_dir(mv_dir), .mv_done(mv_done), .mv_changed(mv_changed),
        .spawn_start(spawn_start), .spawn_done(spawn_done),
        .move_en(move_en), .busy(busy), .game_over(game_over), .game_completed(game_completed),
        .use_win_goal(use_win_goal), .move_count(move_count), .state(state)
    );

    // Count request pulses on the falling edge, away from the DUT edge
    always @(negedge clk) begin
        if (spawn_start) spawn_pulses++;
        if (mv_start)    mv_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
        tick();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    endtask

    // Wait for a spawn request, then answer it three cycles later
    task automatic serve_spawn(input string tag);
        int i;
        i = 0;
        while (!spawn_start && i < 50) begin
            tick();
            i++;
        end
        if (!spawn_start) begin
            check({tag, " spawn_start timeout"}, {31'd0, spawn_start}, 32'd1);
        end else begin
            tick();
            tick();
            spawn_done = 1'b1;
            tick();
            spawn_done = 1'b0;
        end
    endtask

    task automatic run_scan(output int n);
        n = 0;
        while (state == ST_SCAN && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Press, complete the move with a board change, serve the spawn, finish the scan
    task automatic move_and_scan(input string tag, input logic [3:0] b);
        int n;
        press(b);
        mv_done = 1'b1;
        mv_changed = 1'b1;
        tick();
        mv_done = 1'b0;
        mv_changed = 1'b0;
        serve_spawn(tag);
        run_scan(n);
        check({tag, " scan length"}, n, 32'd16);
    endtask

    typedef struct {
        logic [3:0]  btns;      // {up, down, left, right}
        logic        changed;
        logic [1:0]  exp_dir;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int mp;
        int sp;

        vecs[0] = '{4'b0010, 1'b1, 2'b10, 16'd1};  // left, changed
        vecs[1] = '{4'b0100, 1'b0, 2'b01, 16'd1};  // down, unchanged
        vecs[2] = '{4'b1001, 1'b1, 2'b00, 16'd2};  // up+right -> up
        vecs[3] = '{4'b0001, 1'b1, 2'b11, 16'd3};  // right
        vecs[4] = '{4'b0110, 1'b0, 2'b01, 16'd3};  // down+left -> down, unchanged
        vecs[5] = '{4'b1111, 1'b1, 2'b00, 16'd4};  // all -> up

        board[0*TILE_W +: TILE_W] = 4'd1;
        board[1*TILE_W +: TILE_W] = 4'd1;

        // ---------------- reset and initial fill ----------------
        tick();
        check("reset state", state, ST_INIT);
        check("reset mv_start", mv_start, 0);
        check("reset spawn_start", spawn_start, 0);
        check("reset move_en", move_en, 0);
        check("reset busy", busy, 1);
        check("reset game_over", game_over, 0);
        check("reset game_completed", game_completed, 0);
        check("reset move_count", move_count, 0);
        check("reset use_win_goal", use_win_goal, 0);
        check("reset mv_dir", mv_dir, 0);
        rst = 1'b0;
        sp = spawn_pulses;
        tick();
        check("init->spawn state", state, ST_SPAWN);
        check("init spawn_start", spawn_start, 1);
        check("init use_win_goal", use_win_goal, 11);
        serve_spawn("init1");
        check("second spawn request", spawn_start, 1);
        check("still spawning", state, ST_SPAWN);
        serve_spawn("init2");
        check("enter scan", state, ST_SCAN);
        run_scan(n);
        check("init scan length", n, 16);
        check("idle after init", state, ST_IDLE);
        check("idle move_en", move_en, 1);
        check("idle busy", busy, 0);
        check("idle move_count", move_count, 0);
        check("init spawn count", spawn_pulses - sp, 2);

        // ---------------- table-driven moves ----------------
        for (int v = 0; v < 6; v++) begin
            mp = mv_pulses;
            sp = spawn_pulses;
            press(vecs[v].btns);
            check($sformatf("v%0d mv_start", v), mv_start, 1);
            check($sformatf("v%0d mv_dir", v), mv_dir, vecs[v].exp_dir);
            check($sformatf("v%0d state move", v), state, ST_MOVE);
            tick();
            check($sformatf("v%0d mv_start one cycle", v), mv_start, 0);
            mv_done = 1'b1;
            mv_changed = vecs[v].changed;
            tick();
            mv_done = 1'b0;
            mv_changed = 1'b0;
            check($sformatf("v%0d move_count", v), move_count, vecs[v].exp_cnt);
            if (vecs[v].changed) begin
                check($sformatf("v%0d state spawn", v), state, ST_SPAWN);
                serve_spawn($sformatf("v%0d", v));
                run_scan(n);
                check($sformatf("v%0d scan length", v), n, 16);
                check($sformatf("v%0d back idle", v), state, ST_IDLE);
                check($sformatf("v%0d spawn pulses", v), spawn_pulses - sp, 1);
            end else begin
                check($sformatf("v%0d state idle", v), state, ST_IDLE);
                tick();
                check($sformatf("v%0d no spawn", v), spawn_pulses - sp, 0);
            end
            check($sformatf("v%0d mv pulses", v), mv_pulses - mp, 1);
        end

        // ---------------- stray handshakes in IDLE ----------------
        spawn_done = 1'b1;
        mv_done = 1'b1;
        mv_changed = 1'b1;
        tick();
        spawn_done = 1'b0;
        mv_done = 1'b0;
        mv_changed = 1'b0;
        check("stray done state", state, ST_IDLE);
        check("stray done count", move_count, 4);
        check("stray done no spawn", spawn_pulses - sp, 1);

        // ---------------- win and continue ----------------
        board = '0;
        board[15*TILE_W +: TILE_W] = 4'd11;
        move_and_scan("win", 4'b0010);
        check("win state", state, ST_WIN);
        check("win game_completed", game_completed, 1);
        check("win move_en", move_en, 0);
        check("win move_count", move_count, 5);
        mp = mv_pulses;
        press(4'b1000);
        check("continue state", state, ST_IDLE);
        check("continue no mv_start", mv_start, 0);
        tick();
        check("continue no move pulse", mv_pulses - mp, 0);
        check("completed sticky", game_completed, 1);
        move_and_scan("post-win", 4'b0100);
        check("post-win idle", state, ST_IDLE);
        check("post-win count", move_count, 6);

        // ---------------- loss ----------------
        for (int r = 0; r < GRID_N; r++)
            for (int c = 0; c < GRID_N; c++)
                board[(r*GRID_N + c)*TILE_W +: TILE_W] = ((r + c) % 2 != 0) ? 4'd2 : 4'd1;
        move_and_scan("lose", 4'b0001);
        check("lose state", state, ST_LOSE);
        check("lose game_over", game_over, 1);
        check("lose busy", busy, 0);
        mp = mv_pulses;
        press(4'b0010);
        tick();
        tick();
        check("lose ignores buttons", mv_pulses - mp, 0);
        check("lose held", state, ST_LOSE);

        // ---------------- reset from LOSE, goal default ----------------
        win_goal = 4'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2 state", state, ST_INIT);
        check("rst2 game_over", game_over, 0);
        check("rst2 game_completed", game_completed, 0);
        check("rst2 move_count", move_count, 0);
        check("rst2 mv_dir", mv_dir, 0);
        check("rst2 use_win_goal", use_win_goal, 0);
        tick();
        check("goal0 -> 11", use_win_goal, 11);
        check("rst2 spawn", state, ST_SPAWN);

        // ---------------- reset aborting SPAWN, late spawn_done ----------------
        board = '0;
        board[0*TILE_W +: TILE_W] = 4'd1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spawn_done = 1'b1;
        tick();
        spawn_done = 1'b0;
        check("late spawn_done ignored", state, ST_SPAWN);
        serve_spawn("abort1");
        check("abort needs two spawns", state, ST_SPAWN);
        serve_spawn("abort2");
        run_scan(n);
        check("abort idle", state, ST_IDLE);

        // ---------------- reset aborting MOVE, late mv_done ----------------
        press(4'b0001);
        check("abort move state", state, ST_MOVE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        mv_done = 1'b1;
        mv_changed = 1'b1;
        tick();
        mv_done = 1'b0;
        mv_changed = 1'b0;
        check("late mv_done state", state, ST_SPAWN);
        check("late mv_done count", move_count, 0);
        spawn_done = 1'b1;
        tick();
        spawn_done = 1'b0;
        serve_spawn("abort3");
        run_scan(n);
        check("abort move idle", state, ST_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_ctrl_fsm.md
GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  GRID_N, 4, board is GRID_N x GRID_N tiles (legal range 2..8)
  TILE_W, 4, tile exponent width (0 = empty, k = value 2^k)
  CNT_W, 16, move counter width
  ALLOW_CONTINUE, 1, 1 = play may continue after a win; 0 = win is terminal
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  master clock
  rst  in  1  reset (one clock, synchronous, active-high)
  btn_up/btn_down/btn_left/btn_right  in  1 each  debounced single-cycle press pulses
  win_goal  in  TILE_W  goal exponent (0 selects 11)
  board  in  GRID_N*GRID_N*TILE_W  tile exponents; tile (r,c) at bits [(r*GRID_N+c)*TILE_W +: TILE_W]
  mv_start  out  1  one-cycle move request
  mv_dir  out  2  00 up, 01 down, 10 left, 11 right; valid with mv_start and held until next request
  mv_done  in  1  move engine completion pulse
  mv_changed  in  1  board changed by the move; sampled only with mv_done
  spawn_start  out  1  one-cycle random tile spawn request
  spawn_done  in  1  spawn completion pulse
  move_en  out  1  high only in IDLE
  busy  out  1  high in INIT, MOVE, SPAWN and SCAN
  game_over  out  1  sticky loss flag
  game_completed  out  1  sticky win flag
  use_win_goal  out  TILE_W  latched effective goal
  move_count  out  CNT_W  count of moves that changed the board
  state  out  3  current state encoding

Function
REQ-003 States: INIT=000, IDLE=001, MOVE=010, SPAWN=011, SCAN=100, WIN=101, LOSE=110; codes 111 recover to INIT on the next cycle.
REQ-004 INIT: latches use_win_goal = (win_goal==0 ? 11 : win_goal), clears spawn_cnt, pulses spawn_start, goes to SPAWN.
REQ-005 SPAWN: waits for spawn_done and increments spawn_cnt; while spawn_cnt < 2 after INIT, re-pulses spawn_start and stays; otherwise goes to SCAN on the cycle after spawn_done.
REQ-006 IDLE: a button pulse registers mv_dir, asserts mv_start for exactly one cycle on the next clock, and goes to MOVE.
REQ-007 Simultaneous button pulses use priority up > down > left > right.
REQ-008 MOVE: on mv_done with mv_changed=1, increments move_count (saturating at all-ones), pulses spawn_start and goes to SPAWN (single spawn).
REQ-009 MOVE: on mv_done with mv_changed=0, returns to IDLE with no spawn and no count change.
REQ-010 SCAN: visits one tile per cycle, index 0..GRID_N*GRID_N-1, so it takes exactly GRID_N*GRID_N cycles; board is required to be stable throughout.
REQ-011 SCAN accumulates three flags.
  found_goal: tile >= use_win_goal.
  found_empty: tile == 0.
  found_merge: tile nonzero and equal to its right neighbour (c<GRID_N-1) or its lower neighbour (r<GRID_N-1).
REQ-012 SCAN exit (next state after the final index):
  found_goal and won_latched=0 -> WIN
  else found_empty=0 and found_merge=0 -> LOSE
  else -> IDLE
REQ-013 WIN: game_completed=1; with ALLOW_CONTINUE=1, any button pulse sets won_latched and goes to IDLE, and that pulse does not issue a move; with ALLOW_CONTINUE=0, WIN is held until rst.
REQ-014 LOSE: game_over=1; held until rst.
REQ-015 Buttons in MOVE/SPAWN/SCAN/WIN(ALLOW_CONTINUE=0)/LOSE are discarded and never queued.
REQ-016 mv_done outside MOVE and spawn_done outside SPAWN are ignored.
REQ-017 game_completed remains 1 after continuing, until rst.

Reset
REQ-018 With rst=1 at a clock edge, the next state is INIT.
REQ-019 The same edge clears mv_start, spawn_start, move_en, game_over, game_completed, won_latched, move_count, spawn_cnt, scan index and mv_dir to 0, and sets use_win_goal to 0 until INIT latches it.
REQ-020 Reset during MOVE/SPAWN aborts the handshake; a late mv_done/spawn_done after reset is ignored.

Verification (GRID_N=4, win_goal=11)
REQ-021 rst 1 cycle, spawn_done 3 cycles after each request -> two spawn_start pulses, then 16 SCAN cycles, IDLE, move_en=1, move_count=0, use_win_goal=11.
REQ-022 IDLE, btn_left pulse -> mv_start=1 and mv_dir=10 next cycle; mv_done+mv_changed=1 -> move_count=1, one spawn_start, SPAWN.
REQ-023 IDLE, btn_down, mv_done with mv_changed=0 -> back in IDLE, move_count unchanged, no spawn_start.
REQ-024 Board with tile 15 = 11 after a spawn -> WIN and game_completed=1; btn_up -> IDLE with no mv_start; a later scan with the same board -> IDLE.
REQ-025 Full board with no empty tile and no equal neighbours (alternating 1/2) -> LOSE and game_over=1; button pulses produce no mv_start; rst -> game_over=0, INIT.
REQ-026 btn_up and btn_right in the same cycle -> mv_dir=00; win_goal=0 at INIT -> use_win_goal=11.
